// File: rtl/lisp_primop_fold.sv
// Folds a primitive arithmetic opcode (ADD/SUB/MUL/MIN) over a streamed argument list.
// Tag errors drain the remainder of the list and report a single error code.
module lisp_primop_fold #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 16,
    parameter int OP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic              no_args,
    output logic              start_ready,
    input  logic              arg_valid,
    input  logic [TAG_W-1:0]  arg_tag,
    input  logic [DATA_W-1:0] arg_data,
    input  logic              arg_last,
    output logic              arg_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        err_code
);

    // Handshakes: a transfer happens on a rising clk edge where valid (or start)
    // and the matching ready are both high; ready never depends on valid.

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_MIN = 2'd3;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_TYPE  = 2'd1;
    localparam logic [1:0] ERR_ARITY = 2'd2;
    localparam logic [1:0] ERR_BADOP = 2'd3;

    state_t            state, state_next;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] fold;
    logic [1:0]        err;
    logic              first;

    logic       start_fire, arg_fire, res_fire;
    logic       op_bad, arg_bad;
    logic [1:0] op_sel;

    assign start_fire = start && start_ready;
    assign arg_fire   = arg_valid && arg_ready;
    assign res_fire   = res_valid && res_ready;
    assign op_bad     = (op > OP_W'(3));
    assign op_sel     = op[1:0];
    assign arg_bad    = (arg_tag != '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_fire) begin
                    if (no_args)     state_next = DONE;
                    else if (op_bad) state_next = DRAIN;
                    else             state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (arg_fire) begin
                    if (arg_last)     state_next = DONE;
                    else if (arg_bad) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (arg_fire && arg_last) state_next = DONE;
            end
            DONE: begin
                if (res_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start_ready = 1'b0;
        arg_ready   = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        err_code    = err;
        case (state)
            IDLE:  start_ready = 1'b1;
            ACCUM: arg_ready   = 1'b1;
            DRAIN: arg_ready   = 1'b1;
            DONE: begin
                res_valid = 1'b1;
                if (err == ERR_NONE) res_data = acc;
            end
            default: start_ready = 1'b0;
        endcase
    end

    always_comb begin
        fold = acc;
        case (op_q)
            OP_ADD: fold = acc + arg_data;
            OP_SUB: fold = acc - arg_data;
            OP_MUL: fold = acc * arg_data;
            OP_MIN: fold = (arg_data < acc) ? arg_data : acc;
            default: fold = acc;
        endcase
    end

    // Accumulator and error register; a lone SUB argument is negated on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_ADD;
            acc   <= '0;
            err   <= ERR_NONE;
            first <= 1'b0;
        end else if (start_fire) begin
            op_q  <= op_sel;
            first <= 1'b1;
            if (no_args) begin
                acc <= (!op_bad && op_sel == OP_MUL) ? DATA_W'(1) : '0;
                if (op_bad)
                    err <= ERR_BADOP;
                else if (op_sel == OP_SUB || op_sel == OP_MIN)
                    err <= ERR_ARITY;
                else
                    err <= ERR_NONE;
            end else begin
                acc <= '0;
                err <= op_bad ? ERR_BADOP : ERR_NONE;
            end
        end else if (arg_fire && state == ACCUM) begin
            if (arg_bad) begin
                err <= ERR_TYPE;
            end else begin
                first <= 1'b0;
                if (first)
                    acc <= (op_q == OP_SUB && arg_last) ? ('0 - arg_data) : arg_data;
                else
                    acc <= fold;
            end
        end else if (res_fire) begin
            err <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_lisp_primop_fold.sv
// Directed vector bench for lisp_primop_fold: table-driven list applications
// plus hand-written sequences for back-pressure, ignored strobes and reset abort.
module tb_lisp_primop_fold;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op;
    logic        no_args;
    logic        start_ready;
    logic        arg_valid;
    logic [15:0] arg_tag;
    logic [15:0] arg_data;
    logic        arg_last;
    logic        arg_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    lisp_primop_fold #(.DATA_W(16), .TAG_W(16), .OP_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .no_args     (no_args),
        .start_ready (start_ready),
        .arg_valid   (arg_valid),
        .arg_tag     (arg_tag),
        .arg_data    (arg_data),
        .arg_last    (arg_last),
        .arg_ready   (arg_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      op;
        logic             no_args;
        logic [2:0]       n;
        logic [3:0][15:0] tag;
        logic [3:0][15:0] data;
        logic [15:0]      exp_data;
        logic [1:0]       exp_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] o, input logic na, input int n,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input int bad_i, input logic [15:0] bad_tag,
                                input logic [15:0] ed, input logic [1:0] ee);
        vec_t v;
        v.op       = o;
        v.no_args  = na;
        v.n        = 3'(n);
        v.tag      = '0;
        v.data[0]  = d0;
        v.data[1]  = d1;
        v.data[2]  = d2;
        v.data[3]  = d3;
        if (bad_i < 4) v.tag[bad_i] = bad_tag;
        v.exp_data = ed;
        v.exp_err  = ee;
        return v;
    endfunction

    // Entered and left on a falling edge with the DUT idle
    task automatic run_txn(input int idx, input vec_t v);
        check($sformatf("v%0d start_ready idle", idx), start_ready, 1);
        start   = 1'b1;
        op      = v.op;
        no_args = v.no_args;
        @(negedge clk);
        start   = 1'b0;
        no_args = 1'b0;
        if (!v.no_args) begin
            for (int i = 0; i < int'(v.n); i++) begin
                arg_valid = 1'b1;
                arg_tag   = v.tag[i];
                arg_data  = v.data[i];
                arg_last  = (i == int'(v.n) - 1);
                check($sformatf("v%0d arg_ready arg%0d", idx, i), arg_ready, 1);
                check($sformatf("v%0d start_ready busy arg%0d", idx, i), start_ready, 0);
                @(negedge clk);
            end
        end
        // Stray argument strobe while the result is pending must be ignored
        arg_valid = 1'b1;
        arg_last  = 1'b1;
        arg_tag   = 16'h0;
        arg_data  = 16'h1234;
        check($sformatf("v%0d res_valid latency", idx), res_valid, 1);
        check($sformatf("v%0d res_data", idx), res_data, v.exp_data);
        check($sformatf("v%0d err_code", idx), err_code, v.exp_err);
        check($sformatf("v%0d arg_ready done", idx), arg_ready, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        arg_valid = 1'b0;
        arg_last  = 1'b0;
        check($sformatf("v%0d res_valid cleared", idx), res_valid, 0);
        check($sformatf("v%0d start_ready back", idx), start_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = '0;
        no_args   = 1'b0;
        arg_valid = 1'b0;
        arg_tag   = '0;
        arg_data  = '0;
        arg_last  = 1'b0;
        res_ready = 1'b0;

        vecs[0]  = mk(16'd0, 0, 3, 16'd3, 16'd5, 16'hFFFF, 0, 4, 0, 16'h0007, 2'd0);
        vecs[1]  = mk(16'd1, 0, 1, 16'd5, 0, 0, 0, 4, 0, 16'hFFFB, 2'd0);
        vecs[2]  = mk(16'd1, 1, 0, 0, 0, 0, 0, 4, 0, 16'h0000, 2'd2);
        vecs[3]  = mk(16'd2, 0, 3, 16'h0100, 16'h0100, 16'd7, 0, 4, 0, 16'h0000, 2'd0);
        vecs[4]  = mk(16'd3, 0, 3, 16'd9, 16'd2, 16'd4, 0, 4, 0, 16'h0002, 2'd0);
        vecs[5]  = mk(16'd0, 0, 3, 16'd1, 16'd3, 16'd2, 0, 1, 16'd1, 16'h0000, 2'd1);
        vecs[6]  = mk(16'd0, 1, 0, 0, 0, 0, 0, 4, 0, 16'h0000, 2'd0);
        vecs[7]  = mk(16'd2, 1, 0, 0, 0, 0, 0, 4, 0, 16'h0001, 2'd0);
        vecs[8]  = mk(16'd3, 1, 0, 0, 0, 0, 0, 4, 0, 16'h0000, 2'd2);
        vecs[9]  = mk(16'd7, 1, 0, 0, 0, 0, 0, 4, 0, 16'h0000, 2'd3);
        vecs[10] = mk(16'd1, 0, 3, 16'd10, 16'd3, 16'd2, 0, 4, 0, 16'h0005, 2'd0);
        vecs[11] = mk(16'd2, 0, 2, 16'd3, 16'd5, 0, 0, 4, 0, 16'h000F, 2'd0);
        vecs[12] = mk(16'd0, 0, 2, 16'd1, 16'd4, 0, 0, 1, 16'd2, 16'h0000, 2'd1);
        vecs[13] = mk(16'd3, 0, 2, 16'hFFFF, 16'h8000, 0, 0, 4, 0, 16'h8000, 2'd0);
        vecs[14] = mk(16'd1, 0, 1, 16'd0, 0, 0, 0, 4, 0, 16'h0000, 2'd0);
        vecs[15] = mk(16'd4, 0, 2, 16'd1, 16'd2, 0, 0, 4, 0, 16'h0000, 2'd3);

        @(negedge clk);
        check("reset start_ready", start_ready, 1);
        check("reset arg_ready", arg_ready, 0);
        check("reset res_valid", res_valid, 0);
        check("reset res_data", res_data, 0);
        check("reset err_code", err_code, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Argument strobe in IDLE is ignored
        arg_valid = 1'b1;
        arg_last  = 1'b1;
        check("idle arg_ready", arg_ready, 0);
        @(negedge clk);
        arg_valid = 1'b0;
        arg_last  = 1'b0;
        check("idle after stray arg", start_ready, 1);
        check("idle no result", res_valid, 0);

        for (int k = 0; k < NVEC; k++) run_txn(k, vecs[k]);

        // Bad opcode with back-pressure, start held high throughout DONE
        start = 1'b1;
        op    = 16'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            arg_valid = 1'b1;
            arg_data  = 16'(i + 1);
            arg_last  = (i == 1);
            check($sformatf("badop drain arg_ready %0d", i), arg_ready, 1);
            @(negedge clk);
        end
        arg_valid = 1'b0;
        arg_last  = 1'b0;
        start     = 1'b1;
        op        = 16'd0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("badop hold res_valid c%0d", c), res_valid, 1);
            check($sformatf("badop hold res_data c%0d", c), res_data, 0);
            check($sformatf("badop hold err_code c%0d", c), err_code, 3);
            check($sformatf("badop hold start_ready c%0d", c), start_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check("badop released res_valid", res_valid, 0);
        check("badop start ignored in DONE", start_ready, 1);
        @(negedge clk);
        check("badop still idle", start_ready, 1);
        check("badop still idle arg_ready", arg_ready, 0);

        // Reset in the middle of a four-argument ADD
        start = 1'b1;
        op    = 16'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            arg_valid = 1'b1;
            arg_data  = 16'(10 * (i + 1));
            arg_last  = 1'b0;
            @(negedge clk);
        end
        arg_data = 16'd30;
        rst_n    = 1'b0;
        #1;
        check("abort start_ready", start_ready, 1);
        check("abort arg_ready", arg_ready, 0);
        check("abort res_valid", res_valid, 0);
        check("abort res_data", res_data, 0);
        check("abort err_code", err_code, 0);
        arg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-abort no result", res_valid, 0);
        run_txn(100, mk(16'd0, 0, 1, 16'd6, 0, 0, 0, 4, 0, 16'h0006, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
